// File: rtl/regfile_writeback_pkg.sv
// Shared types and helpers for the register-file writeback path.
package regfile_writeback_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 8;

  // One buffered execute result: destination write plus optional overflow byte.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
    logic                  ovf;
    logic [DATA_W-1:0]     over;
  } wb_entry_t;

  // Register index to one-hot register mask.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Execute-result handshake, register-file write port and hazard/status signals.
interface regfile_writeback_if;
  import regfile_writeback_pkg::*;

  // execute side
  logic                  result_valid_i;
  logic                  result_ready_o;
  logic [REG_ADDR_W-1:0] destReg_i;
  logic [DATA_W-1:0]     data_i;
  logic                  overFlag_i;
  logic [DATA_W-1:0]     over_i;
  logic                  wb_stall_i;

  // register-file write port
  logic                  writeFlag_o;
  logic [REG_ADDR_W-1:0] destReg_o;
  logic [DATA_W-1:0]     data_o;
  logic                  overFlag_o;
  logic [DATA_W-1:0]     over_o;

  // status
  logic [NUM_REGS-1:0]   pending_o;
  logic [3:0]            count_o;
  logic                  conflict_o;

  // Producer / observer side (execute stage, register file, decode).
  modport master (
    output result_valid_i, destReg_i, data_i, overFlag_i, over_i, wb_stall_i,
    input  result_ready_o, writeFlag_o, destReg_o, data_o, overFlag_o, over_o,
    input  pending_o, count_o, conflict_o
  );

  // Writeback block side.
  modport slave (
    input  result_valid_i, destReg_i, data_i, overFlag_i, over_i, wb_stall_i,
    output result_ready_o, writeFlag_o, destReg_o, data_o, overFlag_o, over_o,
    output pending_o, count_o, conflict_o
  );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// Small show-ahead FIFO of writeback entries. The head entry is visible
// combinationally so a result can be written the cycle after it is accepted;
// every slot and its valid bit are exported for hazard-mask generation.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  wb_entry_t              wdata,
  output wb_entry_t              head,
  output logic [3:0]             count,
  output wb_entry_t [DEPTH-1:0]  slots,
  output logic [DEPTH-1:0]       slot_valid
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  wb_entry_t        mem_reg [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [3:0]       count_reg;
  logic [DEPTH-1:0] valid_reg;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && (count_reg != FULL_CNT);
  assign do_pop  = pop  && (count_reg != 4'd0);

  // Storage array; written at the tail, no reset needed for payload.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[tail_reg] <= wdata;
    end
  end

  // Pointers (wrap naturally since DEPTH is a power of two), count and slot valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 4'd0;
      valid_reg <= '0;
    end else begin
      if (do_push) begin
        tail_reg            <= tail_reg + 1'b1;
        valid_reg[tail_reg] <= 1'b1;
      end
      if (do_pop) begin
        head_reg <= head_reg + 1'b1;
        // Safe against a same-cycle push: a push never targets the head slot
        // while the FIFO is non-empty and not full-wrapped onto it.
        if (!(do_push && (tail_reg == head_reg))) begin
          valid_reg[head_reg] <= 1'b0;
        end
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 4'd1;
        2'b01:   count_reg <= count_reg - 4'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head       = mem_reg[head_reg];
  assign count      = count_reg;
  assign slot_valid = valid_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slots
      assign slots[gi] = mem_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/regfile_writeback.sv
// Write-side driver for the 8x8 register file: buffers execute results in
// order, issues one register-file write per cycle, drops the overflow byte
// when it would collide with the destination write, and publishes a mask of
// registers that still have writes queued.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int                    DEPTH   = 4,
  parameter logic [REG_ADDR_W-1:0] OVF_REG = 3'd7
) (
  input logic                 clk,
  input logic                 rst,
  regfile_writeback_if.slave  bus
);

  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  wb_entry_t             in_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] slots;
  logic [DEPTH-1:0]      slot_valid;
  logic [3:0]            count;
  logic                  ready;
  logic                  push;
  logic                  non_empty;
  logic                  issue;
  logic                  conflict_next;
  logic                  conflict_reg;
  logic [NUM_REGS-1:0]   pend_term [DEPTH];
  logic [NUM_REGS-1:0]   pending;

  assign in_entry.dest = bus.destReg_i;
  assign in_entry.data = bus.data_i;
  assign in_entry.ovf  = bus.overFlag_i;
  assign in_entry.over = bus.over_i;

  // Ready only looks at current occupancy; a full queue never accepts, even while draining.
  assign ready     = (count != FULL_CNT);
  assign push      = bus.result_valid_i && ready;
  assign non_empty = (count != 4'd0);
  assign issue     = non_empty && !bus.wb_stall_i;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (issue),
    .wdata      (in_entry),
    .head       (head),
    .count      (count),
    .slots      (slots),
    .slot_valid (slot_valid)
  );

  // Overflow byte aimed at the same register as the data write is dropped.
  assign conflict_next = issue && head.ovf && (head.dest == OVF_REG);

  // Conflict flag pulses in the cycle after the offending entry leaves the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_reg <= 1'b0;
    end else begin
      conflict_reg <= conflict_next;
    end
  end

  // Per-slot contribution to the hazard mask: destination plus r7 if carrying overflow.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      assign pend_term[gi] = slot_valid[gi]
                           ? (onehot(slots[gi].dest) | (slots[gi].ovf ? onehot(OVF_REG) : '0))
                           : '0;
    end
  endgenerate

  // OR-reduce the per-slot masks.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending = pending | pend_term[i];
    end
  end

  assign bus.result_ready_o = ready;
  assign bus.writeFlag_o    = issue;
  assign bus.destReg_o      = non_empty ? head.dest : '0;
  assign bus.data_o         = non_empty ? head.data : '0;
  assign bus.over_o         = non_empty ? head.over : '0;
  assign bus.overFlag_o     = issue && head.ovf && (head.dest != OVF_REG);
  assign bus.pending_o      = pending;
  assign bus.count_o        = count;
  assign bus.conflict_o     = conflict_reg;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a queue-based reference model checked
// every cycle, plus literal expectations for each hand-worked scenario.
module tb_regfile_writeback;

  typedef struct {
    logic [2:0] dest;
    logic [7:0] data;
    logic       ovf;
    logic [7:0] over;
  } ent_t;

  typedef struct {
    logic [2:0] dest;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   check_en;

  ent_t mq[$];
  logic conf_exp;
  wr_t  dut_log[$];

  regfile_writeback_if bus();

  regfile_writeback #(
    .DEPTH   (4),
    .OVF_REG (3'd7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: in-order queue of at most 4 entries, updated at each posedge.
  always @(posedge clk) begin
    bit iss;
    bit acc;
    ent_t e;
    if (rst) begin
      mq.delete();
      conf_exp = 1'b0;
    end else begin
      iss = (mq.size() != 0) && !bus.wb_stall_i;
      acc = bus.result_valid_i && (mq.size() < 4);
      conf_exp = iss && mq[0].dest == 3'd7 && mq[0].ovf;
      if (iss) void'(mq.pop_front());
      if (acc) begin
        e.dest = bus.destReg_i;
        e.data = bus.data_i;
        e.ovf  = bus.overFlag_i;
        e.over = bus.over_i;
        mq.push_back(e);
      end
    end
  end

  // Compare process: every cycle, outputs must match what the model queue implies.
  always @(negedge clk) begin
    logic [7:0] pm;
    bit         wf;
    wr_t        w;
    if (check_en) begin
      pm = 8'h00;
      foreach (mq[k]) begin
        pm = pm | (8'h01 << mq[k].dest);
        if (mq[k].ovf) pm = pm | 8'h80;
      end
      wf = (mq.size() != 0) && !bus.wb_stall_i;
      chk("model_count", 32'(bus.count_o), 32'(mq.size()));
      chk("model_ready", 32'(bus.result_ready_o), 32'(mq.size() != 4));
      chk("model_wflag", 32'(bus.writeFlag_o), 32'(wf));
      chk("model_dest",  32'(bus.destReg_o), mq.size() != 0 ? 32'(mq[0].dest) : 32'd0);
      chk("model_data",  32'(bus.data_o),    mq.size() != 0 ? 32'(mq[0].data) : 32'd0);
      chk("model_over",  32'(bus.over_o),    mq.size() != 0 ? 32'(mq[0].over) : 32'd0);
      chk("model_ovflg", 32'(bus.overFlag_o),
          32'(wf && mq[0].ovf && mq[0].dest != 3'd7));
      chk("model_pend",  32'(bus.pending_o), 32'(pm));
      chk("model_confl", 32'(bus.conflict_o), 32'(conf_exp));
      if (bus.writeFlag_o === 1'b1) begin
        w.dest = bus.destReg_o;
        w.data = bus.data_o;
        dut_log.push_back(w);
        $display("write dest=%0d data=%02h ovf=%0b over=%02h count=%0d",
                 bus.destReg_o, bus.data_o, bus.overFlag_o, bus.over_o, bus.count_o);
      end
    end
  end

  task automatic drv(input logic v, input logic [2:0] d, input logic [7:0] dat,
                     input logic o, input logic [7:0] ov, input logic st);
    bus.result_valid_i = v;
    bus.destReg_i      = d;
    bus.data_i         = dat;
    bus.overFlag_i     = o;
    bus.over_i         = ov;
    bus.wb_stall_i     = st;
  endtask

  task automatic idle(input logic st);
    drv(1'b0, 3'd0, 8'h00, 1'b0, 8'h00, st);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx;
    int  cyc;
    bit  done;
    total    = 0;
    bad      = 0;
    check_en = 1'b0;
    conf_exp = 1'b0;
    rst      = 1'b1;
    idle(1'b0);
    next_cycle();
    check_en = 1'b1;
    next_cycle();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_ready", 32'(bus.result_ready_o), 32'd1);
    chk("rst_wflag", 32'(bus.writeFlag_o), 32'd0);
    chk("rst_pend",  32'(bus.pending_o), 32'h00);
    chk("rst_data",  32'(bus.data_o), 32'h00);
    next_cycle();

    // Single write
    drv(1'b1, 3'd2, 8'h5A, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("single_pend_pre", 32'(bus.pending_o), 32'h00);
    next_cycle();
    idle(1'b0);
    @(negedge clk);
    chk("single_wflag", 32'(bus.writeFlag_o), 32'd1);
    chk("single_dest",  32'(bus.destReg_o), 32'd2);
    chk("single_data",  32'(bus.data_o), 32'h5A);
    chk("single_ovflg", 32'(bus.overFlag_o), 32'd0);
    chk("single_pend",  32'(bus.pending_o), 32'h04);
    next_cycle();
    @(negedge clk);
    chk("single_after", 32'(bus.writeFlag_o), 32'd0);
    next_cycle();

    // Overflow write, held in the queue by stall first
    drv(1'b1, 3'd3, 8'h10, 1'b1, 8'hFF, 1'b1);
    next_cycle();
    idle(1'b1);
    @(negedge clk);
    chk("ovf_pend",  32'(bus.pending_o), 32'h88);
    chk("ovf_stall", 32'(bus.writeFlag_o), 32'd0);
    next_cycle();
    idle(1'b0);
    @(negedge clk);
    chk("ovf_wflag", 32'(bus.writeFlag_o), 32'd1);
    chk("ovf_ovflg", 32'(bus.overFlag_o), 32'd1);
    chk("ovf_over",  32'(bus.over_o), 32'hFF);
    chk("ovf_data",  32'(bus.data_o), 32'h10);
    next_cycle();

    // Conflict: overflow aimed at r7 with dest r7
    drv(1'b1, 3'd7, 8'h01, 1'b1, 8'h02, 1'b0);
    next_cycle();
    idle(1'b0);
    @(negedge clk);
    chk("conf_wflag", 32'(bus.writeFlag_o), 32'd1);
    chk("conf_ovflg", 32'(bus.overFlag_o), 32'd0);
    chk("conf_data",  32'(bus.data_o), 32'h01);
    chk("conf_pend",  32'(bus.pending_o), 32'h80);
    chk("conf_pre",   32'(bus.conflict_o), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("conf_pulse", 32'(bus.conflict_o), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("conf_clear", 32'(bus.conflict_o), 32'd0);
    next_cycle();

    // Full / backpressure: 5 pushes under stall, only 4 accepted
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 3'(i), 8'hA0 + 8'(i), 1'b0, 8'h00, 1'b1);
      @(negedge clk);
      chk("full_count", 32'(bus.count_o), 32'(i));
      if (i == 4) chk("full_ready", 32'(bus.result_ready_o), 32'd0);
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      @(negedge clk);
      chk("drain_wflag", 32'(bus.writeFlag_o), 32'd1);
      chk("drain_data",  32'(bus.data_o), 32'hA0 + 32'(i));
      next_cycle();
    end
    @(negedge clk);
    chk("drain_ready", 32'(bus.result_ready_o), 32'd1);
    chk("drain_count", 32'(bus.count_o), 32'd0);
    next_cycle();

    // Alternating stall while streaming 8 results with flow control
    dut_log.delete();
    idx  = 0;
    done = 1'b0;
    for (cyc = 0; cyc < 60 && !done; cyc++) begin
      if (idx < 8)
        drv(1'b1, 3'(idx), 8'hC0 + 8'(idx), idx[0], 8'(idx), cyc[0]);
      else
        idle(cyc[0]);
      @(negedge clk);
      if (idx < 8 && bus.result_ready_o === 1'b1) idx++;
      next_cycle();
      if (idx == 8 && mq.size() == 0) done = 1'b1;
    end
    chk("stream_done", 32'(done), 32'd1);
    chk("stream_nwr",  32'(dut_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < dut_log.size()) begin
        chk("stream_dest", 32'(dut_log[i].dest), 32'(i));
        chk("stream_data", 32'(dut_log[i].data), 32'hC0 + 32'(i));
      end
    end

    // Reset mid-stream with 3 entries queued
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, 3'(i), 8'h30 + 8'(i), 1'b0, 8'h00, 1'b1);
      next_cycle();
    end
    idle(1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_count", 32'(bus.count_o), 32'd3);
    chk("mid_pend",  32'(bus.pending_o), 32'h0E);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", 32'(bus.count_o), 32'd0);
    chk("mid_rst_wflag", 32'(bus.writeFlag_o), 32'd0);
    chk("mid_rst_pend",  32'(bus.pending_o), 32'h00);
    chk("mid_rst_ready", 32'(bus.result_ready_o), 32'd1);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
